// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, controller states
// and the alignment rule applied to every request.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } lsu_state_e;

  // Size 2'b11 is reserved and always rejected.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane steering: extract-and-extend for loads and
// read-modify-write merge for sub-word stores.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter bit LITTLE_END = 1'b1
) (
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [4:0]  bshift;
  logic [4:0]  hshift;
  logic [31:0] bword;
  logic [31:0] hword;

  always_comb begin
    // Big-endian mirrors the lane index: byte 0 sits in the top lane.
    bshift = LITTLE_END ? {off_i, 3'b000} : {~off_i, 3'b000};
    hshift = LITTLE_END ? {off_i[1], 4'b0000} : {~off_i[1], 4'b0000};
    bword  = word_i >> bshift;
    hword  = word_i >> hshift;
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: ext_o = {{24{~uns_i & bword[7]}}, bword[7:0]};
      SZ_HALF: ext_o = {{16{~uns_i & hword[15]}}, hword[15:0]};
      default: ext_o = word_i;
    endcase
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: merged_o = (word_i & ~(32'h0000_00ff << bshift)) |
                          ({24'b0, wdata_i[7:0]} << bshift);
      SZ_HALF: merged_o = (word_i & ~(32'h0000_ffff << hshift)) |
                          ({16'b0, wdata_i[15:0]} << hshift);
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_dm_ctrl.sv
// Load/store controller for the word-addressed data memory; sub-word stores
// are performed as a read cycle followed by a merged write cycle.
module lsu_dm_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DM_AW      = 10,
  parameter bit          LITTLE_END = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [31:0]      rdata,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_wr,
  input  logic [31:0]      dm_dout
);

  lsu_state_e       state_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [DM_AW+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      word_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0] lane_word;
  logic [31:0] lane_ext;
  logic [31:0] lane_merged;

  // Bits above the memory window alias by design.
  logic unused_addr;
  assign unused_addr = ^addr[31:DM_AW+2];

  // Loads extract straight from the memory bus; stores merge into the captured word.
  assign lane_word = (state_q == StRd) ? dm_dout : word_q;

  lsu_lane #(
    .LITTLE_END(LITTLE_END)
  ) u_lane (
    .word_i  (lane_word),
    .wdata_i (wdata_q),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .ext_o   (lane_ext),
    .merged_o(lane_merged)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= uns;
            addr_q  <= addr[DM_AW+1:0];
            wdata_q <= wdata;
            if (misaligned(size, addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q   <= 1'b0;
              state_q <= (we && size == SZ_WORD) ? StWr : StRd;
            end
          end
        end
        StRd: begin
          word_q <= dm_dout;
          if (we_q) begin
            state_q <= StWr;
          end else begin
            rdata_q <= lane_ext;
            state_q <= StResp;
          end
        end
        StWr: state_q <= StResp;
        StResp: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready   = (state_q == StIdle);
  assign done    = (state_q == StResp);
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign dm_addr = addr_q[DM_AW+1:2];
  assign dm_wr   = (state_q == StWr);
  assign dm_din  = dm_wr ? lane_merged : '0;

endmodule

// File: tb/tb_lsu_dm_ctrl.sv
// Directed bench for lsu_dm_ctrl: a transaction-level model predicts per-cycle
// outputs and memory contents; a compare process checks the DUT every cycle.
module tb_lsu_dm_ctrl;

  localparam int unsigned DM_AW = 10;
  localparam bit          LE    = 1'b1;

  logic             clk;
  logic             rstn;
  logic             req;
  logic             we;
  logic [1:0]       size;
  logic             uns;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             ready;
  logic             done;
  logic             err;
  logic [31:0]      rdata;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_din;
  logic             dm_wr;
  logic [31:0]      dm_dout;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  lsu_dm_ctrl #(
    .DM_AW     (DM_AW),
    .LITTLE_END(LE)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .we     (we),
    .size   (size),
    .uns    (uns),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .done   (done),
    .err    (err),
    .rdata  (rdata),
    .dm_addr(dm_addr),
    .dm_din (dm_din),
    .dm_wr  (dm_wr),
    .dm_dout(dm_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory: asynchronous read, write committed on the negedge.
  assign dm_dout = mem[dm_addr];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (dm_wr) mem[dm_addr] = dm_din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory viewed as bytes at byte offsets 0..3 within a word.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return LE ? w[8*k +: 8] : w[8*(3-k) +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    if (LE) r[8*k +: 8] = b;
    else    r[8*(3-k) +: 8] = b;
    return r;
  endfunction

  // Transaction-level model
  logic [31:0] gold [1024];
  bit          m_active = 0;
  int          m_rem = 0;
  bit          m_mis = 0;
  bit          m_we = 0;
  logic [31:0] m_load_val = '0;
  logic [31:0] m_new_word = '0;
  int          m_widx = 0;
  logic [31:0] exp_rdata = '0;

  task automatic m_finish();
    if (!m_mis) begin
      if (!m_we) exp_rdata = m_load_val;
      else gold[m_widx] = m_new_word;
    end
  endtask

  task automatic m_accept();
    int          off;
    int          lat;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    off    = int'(addr[1:0]);
    m_widx = int'(addr[11:2]);
    w      = gold[m_widx];
    m_we   = we;
    m_mis  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00);
    if (m_mis) lat = 1;
    else if (!we || size == 2'b10) lat = 2;
    else lat = 3;
    if (!m_mis && !we) begin
      if (size == 2'b00) begin
        b = byte_of(w, off);
        m_load_val = uns ? {24'b0, b} : {{24{b[7]}}, b};
      end else if (size == 2'b01) begin
        h = LE ? {byte_of(w, off + 1), byte_of(w, off)} : {byte_of(w, off), byte_of(w, off + 1)};
        m_load_val = uns ? {16'b0, h} : {{16{h[15]}}, h};
      end else begin
        m_load_val = w;
      end
    end
    if (!m_mis && we) begin
      m_new_word = w;
      if (size == 2'b00) begin
        m_new_word = put_byte(w, off, wdata[7:0]);
      end else if (size == 2'b01) begin
        m_new_word = put_byte(m_new_word, off,     LE ? wdata[7:0]  : wdata[15:8]);
        m_new_word = put_byte(m_new_word, off + 1, LE ? wdata[15:8] : wdata[7:0]);
      end else begin
        m_new_word = wdata;
      end
    end
    m_active = 1;
    m_rem    = lat - 1;
    if (m_rem == 0) m_finish();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) gold[i] = '0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_active  = 0;
        exp_rdata = '0;
      end else if (m_active) begin
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_finish();
        end else begin
          m_active = 0;
        end
      end else if (req) begin
        m_accept();
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready", {31'b0, ready}, {31'b0, !m_active});
        chk("done", {31'b0, done}, {31'b0, m_active && m_rem == 0});
        chk("dm_wr", {31'b0, dm_wr}, {31'b0, m_active && m_we && !m_mis && m_rem == 1});
        chk("rdata", rdata, exp_rdata);
        if (m_active && m_rem == 0) chk("err", {31'b0, err}, {31'b0, m_mis});
        if (m_active && m_we && !m_mis && m_rem == 1) begin
          chk("dm_addr", {22'b0, dm_addr}, m_widx[31:0]);
          chk("dm_din", dm_din, m_new_word);
        end
      end
    end
  end

  logic        last_err;
  logic [31:0] last_rdata;

  // Called just after a posedge with the DUT idle.
  task automatic issue(input logic iwe, input logic [1:0] isz, input logic iuns,
                       input logic [31:0] iaddr, input logic [31:0] iwd,
                       input int exp_lat, input string nm);
    int lat;
    req = 1'b1; we = iwe; size = isz; uns = iuns; addr = iaddr; wdata = iwd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 10);
    chk({nm, " latency"}, lat[31:0], exp_lat[31:0]);
    last_err   = err;
    last_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0;
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("reset dm_addr", {22'b0, dm_addr}, 32'h0);
    chk("reset dm_din", dm_din, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 2, "sw");
    chk("sw mem4", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 2, "lw");
    chk("lw rdata", last_rdata, 32'hDEADBEEF);
    chk("lw err", {31'b0, last_err}, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 32'h010, 32'h11223344, 2, "sw pre");
    issue(1'b1, 2'b00, 1'b0, 32'h012, 32'h000000AA, 3, "sb");
    chk("sb mem4", mem[4], 32'h11AA3344);

    issue(1'b1, 2'b10, 1'b0, 32'h000, 32'h0000FF80, 2, "sw pre0");
    issue(1'b0, 2'b00, 1'b0, 32'h000, 32'h0, 2, "lb");
    chk("lb", last_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h000, 32'h0, 2, "lbu");
    chk("lbu", last_rdata, 32'h00000080);
    issue(1'b0, 2'b01, 1'b0, 32'h000, 32'h0, 2, "lh");
    chk("lh", last_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 2, "lhu");
    chk("lhu", last_rdata, 32'h00000000);
    issue(1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 1, "mis lh");
    chk("mis lh err", {31'b0, last_err}, 32'h1);
    chk("mis lh rdata", last_rdata, 32'h00000000);
    issue(1'b0, 2'b00, 1'b0, 32'h003, 32'h0, 2, "lb hi");
    chk("lb hi", last_rdata, 32'h00000000);
    issue(1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 2, "lb 1");
    chk("lb 1", last_rdata, 32'hFFFFFFFF);
    issue(1'b1, 2'b10, 1'b0, 32'h002, 32'h12345678, 1, "mis sw");
    chk("mis sw err", {31'b0, last_err}, 32'h1);
    chk("mis sw rdata", last_rdata, 32'hFFFFFFFF);
    issue(1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 1, "mis sz3");
    chk("mis sz3 err", {31'b0, last_err}, 32'h1);
    chk("mis mem0", mem[0], 32'h0000FF80);

    // Reset during the read half of a halfword RMW
    issue(1'b1, 2'b10, 1'b0, 32'h020, 32'h55667788, 2, "sw pre8");
    req = 1'b1; we = 1'b1; size = 2'b01; uns = 1'b0; addr = 32'h020; wdata = 32'h1234;
    @(posedge clk);
    #1 req = 1'b0; rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst ready", {31'b0, ready}, 32'h1);
    chk("rst mem8", mem[8], 32'h55667788);
    @(posedge clk);
    #1;

    // Address wrap plus back-to-back with req held high
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h1004; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 we = 1'b0; addr = 32'h004;
    @(negedge clk);
    chk("wrap dm_wr", {31'b0, dm_wr}, 32'h1);
    chk("wrap dm_addr", {22'b0, dm_addr}, 32'h1);
    repeat (3) @(posedge clk);
    #1 req = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 10);
      chk("b2b latency", n[31:0], 32'd2);
    end
    chk("b2b rdata", rdata, 32'hCAFEF00D);
    chk("wrap mem1", mem[1], 32'hCAFEF00D);
    chk("wrap mem0", mem[0], 32'h0000FF80);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
